// File: rtl/sata_oob_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sata_oob_pkg
// Description : Shared constants and helpers for the SATA out-of-band (OOB)
//               receive detector. Holds the nominal OOB timing in ns, the
//               minimum burst length in UI, the gap classification type and
//               an ns-to-cycles conversion.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sata_oob_pkg;

    // Nominal OOB timing, in ns
    localparam real BURST_NOM_NS     = 106.7;
    localparam real WAKE_GAP_MIN_NS  = 55.0;
    localparam real GAP_SPLIT_NS     = 175.0;
    localparam real RESET_GAP_MAX_NS = 525.0;

    // Shortest active run accepted as a burst, in UI
    localparam int  BURST_MIN_UI     = 4;

    typedef enum logic [1:0] {
        GAP_INVALID = 2'd0,
        GAP_WAKE    = 2'd1,
        GAP_RESET   = 2'd2
    } gap_class_e;

    // Whole sampling-clock cycles in 'ns', truncated toward zero.
    function automatic int ns_to_cycles(input real ns, input real sym_ns,
                                        input int oversample);
        return $rtoi(ns / (sym_ns / real'(oversample)));
    endfunction

endpackage : sata_oob_pkg
`default_nettype wire

// File: rtl/sata_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sata_sync2
// Description : Generic two-flop synchronizer with asynchronous active-low
//               reset to a configurable value.
// Ports       : i_clk     - destination clock
//               i_reset_n - asynchronous active-low reset
//               i_d       - asynchronous input
//               o_q       - synchronized output (2 cycles of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module sata_sync2 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule : sata_sync2
`default_nettype wire

// File: rtl/mdl_srx_comsigs.sv
`default_nettype none
// ============================================================================
// Module      : mdl_srx_comsigs
// Description : SATA OOB receive detector. Measures burst and electrical-idle
//               run lengths on the serial input and flags COMRESET/COMINIT or
//               COMWAKE sequences after three bursts with matching gaps.
// Ports       : i_clk      - sampling clock (OVERSAMPLE cycles per UI)
//               i_reset_n  - asynchronous active-low reset
//               i_rx_p     - serial input, positive leg
//               i_rx_n     - serial input, negative leg
//               o_comreset - COMRESET/COMINIT detected (level, registered)
//               o_comwake  - COMWAKE detected (level, registered)
// Revision    : 1.0 - initial release
// ============================================================================
module mdl_srx_comsigs
    import sata_oob_pkg::*;
#(
    parameter int  OVERSAMPLE   = 4,
    parameter real CLOCK_SYM_NS = 1000.0 / 1500.0
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_rx_p,
    input  logic i_rx_n,
    output logic o_comreset,
    output logic o_comwake
);

    localparam int BURST_MIN_CYC     = BURST_MIN_UI * OVERSAMPLE;
    localparam int BURST_MAX_CYC     = ns_to_cycles(2.0 * BURST_NOM_NS, CLOCK_SYM_NS, OVERSAMPLE);
    localparam int WAKE_GAP_MIN_CYC  = ns_to_cycles(WAKE_GAP_MIN_NS, CLOCK_SYM_NS, OVERSAMPLE);
    localparam int GAP_SPLIT_CYC     = ns_to_cycles(GAP_SPLIT_NS, CLOCK_SYM_NS, OVERSAMPLE);
    localparam int RESET_GAP_MAX_CYC = ns_to_cycles(RESET_GAP_MAX_NS, CLOCK_SYM_NS, OVERSAMPLE);

    // The run counter must be able to reach one past the largest threshold.
    localparam int RUN_LIMIT = (RESET_GAP_MAX_CYC > BURST_MAX_CYC) ? RESET_GAP_MAX_CYC
                                                                   : BURST_MAX_CYC;
    localparam int RUN_W     = $clog2(RUN_LIMIT + 2);

    localparam logic [RUN_W-1:0] C_BURST_MIN     = RUN_W'(BURST_MIN_CYC);
    localparam logic [RUN_W-1:0] C_BURST_MAX     = RUN_W'(BURST_MAX_CYC);
    localparam logic [RUN_W-1:0] C_WAKE_GAP_MIN  = RUN_W'(WAKE_GAP_MIN_CYC);
    localparam logic [RUN_W-1:0] C_GAP_SPLIT     = RUN_W'(GAP_SPLIT_CYC);
    localparam logic [RUN_W-1:0] C_RESET_GAP_MAX = RUN_W'(RESET_GAP_MAX_CYC);

    logic             w_raw_active;
    logic             w_act;
    logic [RUN_W-1:0] w_run_inc;
    logic [RUN_W:0]   w_merge_sum;
    logic [RUN_W-1:0] w_merged;
    logic [1:0]       w_rst_inc;
    logic [1:0]       w_wake_inc;
    gap_class_e       w_gap_class;

    logic             act_q, act_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [RUN_W-1:0] gap_q, gap_d;
    logic [1:0]       rst_cnt_q, rst_cnt_d;
    logic [1:0]       wake_cnt_q, wake_cnt_d;
    logic [1:0]       snap_rst_q, snap_rst_d;
    logic [1:0]       snap_wake_q, snap_wake_d;
    logic             snap_comreset_q, snap_comreset_d;
    logic             snap_comwake_q, snap_comwake_d;
    logic             comreset_q, comreset_d;
    logic             comwake_q, comwake_d;

    // Only a clean complementary pair is activity; equal legs, X or Z are idle.
    assign w_raw_active = ((i_rx_p ^ i_rx_n) === 1'b1);

    sata_sync2 #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_sync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_d       (w_raw_active),
        .o_q       (w_act)
    );

    // run_q counts the cycles of the current level seen before this cycle,
    // so on a polarity change it is exactly the length of the run just ended.
    assign w_run_inc   = (run_q == '1) ? run_q : run_q + 1'b1;
    assign w_merge_sum = {1'b0, gap_q} + {1'b0, run_q} + (RUN_W + 1)'(1);
    assign w_merged    = w_merge_sum[RUN_W] ? '1 : w_merge_sum[RUN_W-1:0];
    assign w_rst_inc   = (rst_cnt_q == 2'd3) ? 2'd3 : rst_cnt_q + 2'd1;
    assign w_wake_inc  = (wake_cnt_q == 2'd3) ? 2'd3 : wake_cnt_q + 2'd1;

    always_comb begin
        w_gap_class = GAP_INVALID;
        if (run_q >= C_WAKE_GAP_MIN && run_q < C_GAP_SPLIT) begin
            w_gap_class = GAP_WAKE;
        end else if (run_q >= C_GAP_SPLIT && run_q <= C_RESET_GAP_MAX) begin
            w_gap_class = GAP_RESET;
        end
    end

    always_comb begin
        act_d           = act_q;
        run_d           = run_q;
        gap_d           = gap_q;
        rst_cnt_d       = rst_cnt_q;
        wake_cnt_d      = wake_cnt_q;
        snap_rst_d      = snap_rst_q;
        snap_wake_d     = snap_wake_q;
        snap_comreset_d = snap_comreset_q;
        snap_comwake_d  = snap_comwake_q;
        comreset_d      = comreset_q;
        comwake_d       = comwake_q;

        if (w_act != act_q) begin
            act_d = w_act;
            run_d = RUN_W'(1);
            if (w_act) begin
                // Idle -> active: classify the gap immediately so the output
                // can rise 3 cycles into the burst. The pre-classification
                // state is kept in case this turns out to be a glitch.
                gap_d           = run_q;
                snap_rst_d      = rst_cnt_q;
                snap_wake_d     = wake_cnt_q;
                snap_comreset_d = comreset_q;
                snap_comwake_d  = comwake_q;
                unique case (w_gap_class)
                    GAP_WAKE: begin
                        wake_cnt_d = w_wake_inc;
                        rst_cnt_d  = 2'd0;
                        if (w_wake_inc >= 2'd2) begin
                            comwake_d  = 1'b1;
                            comreset_d = 1'b0;
                        end
                    end
                    GAP_RESET: begin
                        rst_cnt_d  = w_rst_inc;
                        wake_cnt_d = 2'd0;
                        if (w_rst_inc >= 2'd2) begin
                            comreset_d = 1'b1;
                            comwake_d  = 1'b0;
                        end
                    end
                    default: begin
                        rst_cnt_d  = 2'd0;
                        wake_cnt_d = 2'd0;
                        comreset_d = 1'b0;
                        comwake_d  = 1'b0;
                    end
                endcase
            end else if (run_q < C_BURST_MIN) begin
                // Active run too short to be a burst: undo its classification
                // and fold it, plus this cycle, back into the surrounding gap.
                run_d      = w_merged;
                rst_cnt_d  = snap_rst_q;
                wake_cnt_d = snap_wake_q;
                comreset_d = snap_comreset_q;
                comwake_d  = snap_comwake_q;
            end
        end else begin
            run_d = w_run_inc;
            if (act_q) begin
                // Burst far longer than OOB: the link is carrying data.
                if (run_q > C_BURST_MAX) begin
                    rst_cnt_d  = 2'd0;
                    wake_cnt_d = 2'd0;
                    comreset_d = 1'b0;
                    comwake_d  = 1'b0;
                end
            end else begin
                if (run_q > C_GAP_SPLIT) begin
                    comwake_d = 1'b0;
                end
                if (run_q > C_RESET_GAP_MAX) begin
                    rst_cnt_d  = 2'd0;
                    wake_cnt_d = 2'd0;
                    comreset_d = 1'b0;
                    comwake_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            act_q           <= 1'b0;
            run_q           <= '0;
            gap_q           <= '0;
            rst_cnt_q       <= 2'd0;
            wake_cnt_q      <= 2'd0;
            snap_rst_q      <= 2'd0;
            snap_wake_q     <= 2'd0;
            snap_comreset_q <= 1'b0;
            snap_comwake_q  <= 1'b0;
            comreset_q      <= 1'b0;
            comwake_q       <= 1'b0;
        end else begin
            act_q           <= act_d;
            run_q           <= run_d;
            gap_q           <= gap_d;
            rst_cnt_q       <= rst_cnt_d;
            wake_cnt_q      <= wake_cnt_d;
            snap_rst_q      <= snap_rst_d;
            snap_wake_q     <= snap_wake_d;
            snap_comreset_q <= snap_comreset_d;
            snap_comwake_q  <= snap_comwake_d;
            comreset_q      <= comreset_d;
            comwake_q       <= comwake_d;
        end
    end

    assign o_comreset = comreset_q;
    assign o_comwake  = comwake_q;

endmodule : mdl_srx_comsigs
`default_nettype wire

// File: tb/tb_mdl_srx_comsigs.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mdl_srx_comsigs
// Description : Directed self-checking bench for the SATA OOB detector.
//               Stimulus is counted in sampling-clock cycles; bursts are an
//               alternating D24.3-style pattern, gaps are equal legs.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdl_srx_comsigs;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_rx_p;
    logic        i_rx_n;
    logic        o_comreset;
    logic        o_comwake;

    int          checks;
    int          failures;
    logic [31:0] phase;

    mdl_srx_comsigs dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_rx_p     (i_rx_p),
        .i_rx_n     (i_rx_n),
        .o_comreset (o_comreset),
        .o_comwake  (o_comwake)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // mode 0: idle low/low, 1: active burst, 2: idle high/high
    task automatic cyc(input int mode);
        if (mode == 1) begin
            i_rx_p = phase[3];
            i_rx_n = ~phase[3];
        end else if (mode == 2) begin
            i_rx_p = 1'b1;
            i_rx_n = 1'b1;
        end else begin
            i_rx_p = 1'b0;
            i_rx_n = 1'b0;
        end
        phase = phase + 32'd1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic burst(input int n);
        for (int k = 0; k < n; k++) cyc(1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0);
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        idle(3);
        i_reset_n = 1'b1;
        idle(20);
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        burst(5);
        checks++;
        if (o_comreset !== 1'b0 || o_comwake !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got comreset=%b comwake=%b, want 0 0", o_comreset, o_comwake);
        end
        i_reset_n = 1'b1;
        idle(20);
        checks++;
        if (dut.rst_cnt_q !== 2'd0 || dut.wake_cnt_q !== 2'd0) begin
            failures++;
            $display("FAIL reset_counters: got rst=%0d wake=%0d, want 0 0", dut.rst_cnt_q, dut.wake_cnt_q);
        end
    endtask

    task automatic test_comreset();
        do_reset();
        burst(640); idle(1920);
        burst(3);
        checks++;
        if (o_comreset !== 1'b0) begin
            failures++;
            $display("FAIL comreset_b2: got %b want 0", o_comreset);
        end
        burst(637); idle(1920);
        burst(2);
        checks++;
        if (o_comreset !== 1'b0) begin
            failures++;
            $display("FAIL comreset_b3_early: got %b want 0", o_comreset);
        end
        burst(1);
        checks++;
        if (o_comreset !== 1'b1) begin
            failures++;
            $display("FAIL comreset_b3_rise: got %b want 1", o_comreset);
        end
        burst(637);
        for (int b = 4; b <= 6; b++) begin
            idle(1920); burst(640);
            checks++;
            if (o_comreset !== 1'b1 || o_comwake !== 1'b0) begin
                failures++;
                $display("FAIL comreset_hold_b%0d: got comreset=%b comwake=%b, want 1 0", b, o_comreset, o_comwake);
            end
        end
        idle(3153);
        checks++;
        if (o_comreset !== 1'b1) begin
            failures++;
            $display("FAIL comreset_idle_3153: got %b want 1", o_comreset);
        end
        idle(1);
        checks++;
        if (o_comreset !== 1'b0 || o_comwake !== 1'b0) begin
            failures++;
            $display("FAIL comreset_idle_fall: got comreset=%b comwake=%b, want 0 0", o_comreset, o_comwake);
        end
    endtask

    task automatic test_comwake();
        do_reset();
        burst(640); idle(640);
        burst(640); idle(640);
        burst(2);
        checks++;
        if (o_comwake !== 1'b0) begin
            failures++;
            $display("FAIL comwake_b3_early: got %b want 0", o_comwake);
        end
        burst(1);
        checks++;
        if (o_comwake !== 1'b1 || o_comreset !== 1'b0) begin
            failures++;
            $display("FAIL comwake_b3_rise: got comwake=%b comreset=%b, want 1 0", o_comwake, o_comreset);
        end
        burst(637);
        for (int b = 4; b <= 6; b++) begin
            idle(640); burst(640);
        end
        idle(1053);
        checks++;
        if (o_comwake !== 1'b1) begin
            failures++;
            $display("FAIL comwake_idle_1053: got %b want 1", o_comwake);
        end
        idle(1);
        checks++;
        if (o_comwake !== 1'b0 || o_comreset !== 1'b0) begin
            failures++;
            $display("FAIL comwake_idle_fall: got comwake=%b comreset=%b, want 0 0", o_comwake, o_comreset);
        end
    endtask

    task automatic test_to_data();
        do_reset();
        burst(640); idle(640);
        burst(640); idle(640);
        burst(3);
        burst(1280);
        checks++;
        if (o_comwake !== 1'b1) begin
            failures++;
            $display("FAIL data_run_1283: got %b want 1", o_comwake);
        end
        burst(1);
        checks++;
        if (o_comwake !== 1'b0) begin
            failures++;
            $display("FAIL data_run_fall: got %b want 0", o_comwake);
        end
        burst(200);
        checks++;
        if (o_comwake !== 1'b0 || o_comreset !== 1'b0 || dut.wake_cnt_q !== 2'd0) begin
            failures++;
            $display("FAIL data_run_stay: got comwake=%b comreset=%b wake=%0d, want 0 0 0", o_comwake, o_comreset, dut.wake_cnt_q);
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        burst(640); idle(1920);
        burst(3);
        checks++;
        if (dut.rst_cnt_q !== 2'd1) begin
            failures++;
            $display("FAIL oor_setup_rst: got %0d want 1", dut.rst_cnt_q);
        end
        burst(637); idle(200);
        burst(3);
        checks++;
        if (dut.rst_cnt_q !== 2'd0 || dut.wake_cnt_q !== 2'd0 || o_comreset !== 1'b0 || o_comwake !== 1'b0) begin
            failures++;
            $display("FAIL oor_short_gap: got rst=%0d wake=%0d comreset=%b comwake=%b, want 0 0 0 0", dut.rst_cnt_q, dut.wake_cnt_q, o_comreset, o_comwake);
        end
        burst(637); idle(640);
        burst(3);
        checks++;
        if (dut.wake_cnt_q !== 2'd1) begin
            failures++;
            $display("FAIL oor_setup_wake: got %0d want 1", dut.wake_cnt_q);
        end
        burst(637); idle(3600);
        burst(3);
        checks++;
        if (dut.rst_cnt_q !== 2'd0 || dut.wake_cnt_q !== 2'd0 || o_comreset !== 1'b0 || o_comwake !== 1'b0) begin
            failures++;
            $display("FAIL oor_long_gap: got rst=%0d wake=%0d comreset=%b comwake=%b, want 0 0 0 0", dut.rst_cnt_q, dut.wake_cnt_q, o_comreset, o_comwake);
        end
        burst(637);
    endtask

    task automatic test_mixed();
        do_reset();
        burst(640); idle(640);
        burst(640); idle(640);
        burst(640); idle(1920);
        burst(3);
        checks++;
        if (dut.rst_cnt_q !== 2'd1 || dut.wake_cnt_q !== 2'd0 || o_comreset !== 1'b0 || o_comwake !== 1'b0) begin
            failures++;
            $display("FAIL mixed_counts: got rst=%0d wake=%0d comreset=%b comwake=%b, want 1 0 0 0", dut.rst_cnt_q, dut.wake_cnt_q, o_comreset, o_comwake);
        end
        burst(637);
    endtask

    task automatic test_async_reset();
        do_reset();
        burst(640); idle(1920);
        burst(640); idle(1920);
        burst(640); idle(1920);
        burst(100);
        checks++;
        if (o_comreset !== 1'b1) begin
            failures++;
            $display("FAIL arst_before: got %b want 1", o_comreset);
        end
        #2;
        i_reset_n = 1'b0;
        #1;
        checks++;
        if (o_comreset !== 1'b0) begin
            failures++;
            $display("FAIL arst_immediate: got %b want 0", o_comreset);
        end
        burst(5);
        i_reset_n = 1'b1;
        burst(535); idle(1920);
        burst(3);
        checks++;
        if (o_comreset !== 1'b0 || dut.rst_cnt_q !== 2'd1) begin
            failures++;
            $display("FAIL arst_fresh_b2: got comreset=%b rst=%0d, want 0 1", o_comreset, dut.rst_cnt_q);
        end
        burst(637); idle(1920);
        burst(3);
        checks++;
        if (o_comreset !== 1'b1) begin
            failures++;
            $display("FAIL arst_fresh_b3: got %b want 1", o_comreset);
        end
        burst(637);
    endtask

    task automatic test_glitch();
        do_reset();
        burst(640);
        for (int k = 0; k < 955; k++) cyc(2);
        burst(10);
        for (int k = 0; k < 955; k++) cyc(2);
        burst(3);
        checks++;
        if (o_comwake !== 1'b0 || dut.rst_cnt_q !== 2'd1 || dut.wake_cnt_q !== 2'd0) begin
            failures++;
            $display("FAIL glitch_b2: got comwake=%b rst=%0d wake=%0d, want 0 1 0", o_comwake, dut.rst_cnt_q, dut.wake_cnt_q);
        end
        burst(637); idle(1920);
        burst(3);
        checks++;
        if (o_comreset !== 1'b1 || o_comwake !== 1'b0) begin
            failures++;
            $display("FAIL glitch_b3: got comreset=%b comwake=%b, want 1 0", o_comreset, o_comwake);
        end
        burst(637);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        phase     = 32'd0;
        i_reset_n = 1'b0;
        i_rx_p    = 1'b0;
        i_rx_n    = 1'b0;
        test_reset();
        test_comreset();
        test_comwake();
        test_to_data();
        test_out_of_range();
        test_mixed();
        test_async_reset();
        test_glitch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mdl_srx_comsigs
`default_nettype wire
